// File: rtl/nn_pkg.sv
// Shared constants, slot map and FSM state type for the nn_node front end.
// No logic of its own; zero latency.
// No flow control; consumers apply their own handshakes.
package nn_pkg;

   localparam int DATA_W    = 16;
   localparam int N_IN      = 4;
   localparam int N_HID     = 4;
   localparam int N_OUT     = 2;
   localparam int N_W_IH    = N_IN * N_HID;
   localparam int N_W_HO    = N_HID * N_OUT;
   localparam int N_WORDS   = N_IN + N_W_IH + N_W_HO;

   // Slot base offsets inside the 28-word operand stream
   localparam int X_BASE    = 0;
   localparam int W_IH_BASE = N_IN;
   localparam int W_HO_BASE = N_IN + N_W_IH;

   localparam int WCNT_W    = 5;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_RUN,
      ST_SEND0,
      ST_SEND1
   } drv_state_t;

endpackage

// File: rtl/nn_operand_bank.sv
// 28-entry operand register file feeding the nn_node parallel operand buses.
// Write lands one cycle after the write edge; buses come straight from the registers.
// No backpressure; the writer decides when we is asserted.
module nn_operand_bank #(
   parameter int DATA_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [4:0]                    idx,
   input  logic [DATA_W-1:0]             wdata,
   output logic [nn_pkg::N_IN*DATA_W-1:0]   x_flat,
   output logic [nn_pkg::N_W_IH*DATA_W-1:0] w_ih_flat,
   output logic [nn_pkg::N_W_HO*DATA_W-1:0] w_ho_flat
);
   import nn_pkg::*;

   localparam logic [4:0] LAST_SLOT = 5'(N_WORDS - 1);

   logic [DATA_W-1:0] mem [N_WORDS];

   // Clear on reset, otherwise write the addressed slot; out-of-range indices are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (idx <= LAST_SLOT)) begin
         mem[idx] <= wdata;
      end
   end

   // Slots map onto the flat buses in stream order, lowest slot in the LSBs
   for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
      assign x_flat[gi*DATA_W +: DATA_W] = mem[X_BASE + gi];
   end
   for (genvar gi = 0; gi < N_W_IH; gi++) begin : g_wih
      assign w_ih_flat[gi*DATA_W +: DATA_W] = mem[W_IH_BASE + gi];
   end
   for (genvar gi = 0; gi < N_W_HO; gi++) begin : g_who
      assign w_ho_flat[gi*DATA_W +: DATA_W] = mem[W_HO_BASE + gi];
   end

endmodule

// File: rtl/nn_node_driver.sv
// Deserialises 28 operand words for nn_node, waits for its result, returns 2 result words.
// node_in_ready one cycle after the 28th word; m_valid one cycle after the result capture.
// s_ready low outside LOAD; SEND words hold while m_ready is low; RUN aborts after TIMEOUT cycles.
module nn_node_driver #(
   parameter int DATA_W  = nn_pkg::DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [nn_pkg::N_IN*DATA_W-1:0]   x_flat,
   output logic [nn_pkg::N_W_IH*DATA_W-1:0] w_ih_flat,
   output logic [nn_pkg::N_W_HO*DATA_W-1:0] w_ho_flat,
   output logic                          node_in_ready,
   input  logic                          node_out_ready,
   input  logic [DATA_W-1:0]             node_out0,
   input  logic [DATA_W-1:0]             node_out1,
   output logic [DATA_W-1:0]             m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_last,
   output logic                          busy,
   output logic                          timeout_err
);
   import nn_pkg::*;

   localparam int                 RCNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [RCNT_W-1:0]  RCNT_LAST = RCNT_W'(TIMEOUT - 1);
   localparam logic [WCNT_W-1:0]  LAST_SLOT = WCNT_W'(N_WORDS - 1);

   drv_state_t        state;
   logic [WCNT_W-1:0] wcnt;
   logic [RCNT_W-1:0] rcnt;
   logic [DATA_W-1:0] result0;
   logic [DATA_W-1:0] result1;
   logic              bank_we;

   assign bank_we = s_valid && s_ready;

   nn_operand_bank #(
      .DATA_W (DATA_W)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .we        (bank_we),
      .idx       (wcnt),
      .wdata     (s_data),
      .x_flat    (x_flat),
      .w_ih_flat (w_ih_flat),
      .w_ho_flat (w_ho_flat)
   );

   // Sequencer FSM; every output is a register updated on the transition that changes it
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_LOAD;
         wcnt          <= '0;
         rcnt          <= '0;
         result0       <= '0;
         result1       <= '0;
         s_ready       <= 1'b1;
         node_in_ready <= 1'b0;
         m_data        <= '0;
         m_valid       <= 1'b0;
         m_last        <= 1'b0;
         busy          <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            ST_LOAD: begin
               if (bank_we) begin
                  if (wcnt == LAST_SLOT) begin
                     wcnt          <= '0;
                     rcnt          <= '0;
                     state         <= ST_RUN;
                     s_ready       <= 1'b0;
                     node_in_ready <= 1'b1;
                     busy          <= 1'b1;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               // rcnt == 0 masks a stale out_ready level left over from the last run
               if ((rcnt != '0) && node_out_ready) begin
                  result0       <= node_out0;
                  result1       <= node_out1;
                  m_data        <= node_out0;
                  m_valid       <= 1'b1;
                  m_last        <= 1'b0;
                  node_in_ready <= 1'b0;
                  rcnt          <= '0;
                  state         <= ST_SEND0;
               end else if (rcnt == RCNT_LAST) begin
                  timeout_err   <= 1'b1;
                  node_in_ready <= 1'b0;
                  busy          <= 1'b0;
                  s_ready       <= 1'b1;
                  rcnt          <= '0;
                  state         <= ST_LOAD;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            ST_SEND0: begin
               if (m_ready) begin
                  m_data <= result1;
                  m_last <= 1'b1;
                  state  <= ST_SEND1;
               end
            end
            ST_SEND1: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
                  busy    <= 1'b0;
                  s_ready <= 1'b1;
                  state   <= ST_LOAD;
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_node_driver.sv
// Scoreboard bench for nn_node_driver with a small behavioural nn_node model.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
// Covers load order, result return, m_ready stalls, stale out_ready, timeout and mid-load reset.
module tb_nn_node_driver;

   localparam int DW = 16;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [DW-1:0]  s_data;
   logic           s_valid;
   logic           s_ready;
   logic [4*DW-1:0]  x_flat;
   logic [16*DW-1:0] w_ih_flat;
   logic [8*DW-1:0]  w_ho_flat;
   logic           node_in_ready;
   logic           node_out_ready;
   logic [DW-1:0]  node_out0;
   logic [DW-1:0]  node_out1;
   logic [DW-1:0]  m_data;
   logic           m_valid;
   logic           m_ready;
   logic           m_last;
   logic           busy;
   logic           timeout_err;

   always #5 clk = ~clk;

   nn_node_driver #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .x_flat         (x_flat),
      .w_ih_flat      (w_ih_flat),
      .w_ho_flat      (w_ho_flat),
      .node_in_ready  (node_in_ready),
      .node_out_ready (node_out_ready),
      .node_out0      (node_out0),
      .node_out1      (node_out1),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_last         (m_last),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } res_t;

   res_t          exp_q[$];
   res_t          sb_r;
   logic [DW-1:0] slots [28];

   // node model: 0 = out_ready some cycles after in_ready, 1 = tied high, 2 = tied low
   int            node_mode  = 0;
   int            node_delay = 3;
   int            in_cnt     = 0;
   logic [DW-1:0] nd_out0    = '0;
   logic [DW-1:0] nd_out1    = '0;

   // Behavioural nn_node: result appears node_delay cycles after in_ready
   always begin
      @(negedge clk);
      #1;
      in_cnt = node_in_ready ? in_cnt + 1 : 0;
      node_out0 = nd_out0;
      node_out1 = nd_out1;
      case (node_mode)
         1:       node_out_ready = 1'b1;
         2:       node_out_ready = 1'b0;
         default: node_out_ready = node_in_ready && (in_cnt > node_delay);
      endcase
   end

   // Scoreboard: each result handshake pops and compares one expected word
   always begin
      @(negedge clk);
      #2;
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_result", exp_q.size(), 1);
         end else begin
            sb_r = exp_q.pop_front();
            check("sb_data", m_data, sb_r.data);
            check("sb_last", m_last, sb_r.last);
         end
      end
   end

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         s_data  = slots[i];
         s_valid = 1'b1;
         while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) check("load_s_ready_timeout", guard, 0);
         if (i == 27) check("in_ready_before_last", node_in_ready, 0);
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic check_buses(input string tag);
      logic [4*DW-1:0]  xe;
      logic [16*DW-1:0] wie;
      logic [8*DW-1:0]  woe;
      for (int i = 0; i < 4; i++)  xe[i*DW +: DW]  = slots[i];
      for (int i = 0; i < 16; i++) wie[i*DW +: DW] = slots[4 + i];
      for (int i = 0; i < 8; i++)  woe[i*DW +: DW] = slots[20 + i];
      check({tag, "_x_flat"}, x_flat, xe);
      check({tag, "_w_ih_flat"}, w_ih_flat, wie);
      check({tag, "_w_ho_flat"}, w_ho_flat, woe);
   endtask

   task automatic drain(input string tag);
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      @(negedge clk);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_s_ready_after"}, s_ready, 1);
   endtask

   task automatic push_results(input logic [DW-1:0] o0, input logic [DW-1:0] o1);
      nd_out0 = o0;
      nd_out1 = o1;
      exp_q.push_back('{data: o0, last: 1'b0});
      exp_q.push_back('{data: o1, last: 1'b1});
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_s_ready"}, s_ready, 1);
      check({tag, "_node_in_ready"}, node_in_ready, 0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_last"}, m_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_x_flat"}, x_flat, 0);
      check({tag, "_w_ih_flat"}, w_ih_flat, 0);
      check({tag, "_w_ho_flat"}, w_ho_flat, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int run_cyc, te_cnt, mv_cnt, g;
      logic te_sready;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // Directed operand set: x, w_ih and w_ho with the named weights in place
      for (int i = 0; i < 28; i++) slots[i] = 16'(16'h0100 + i);
      slots[0] = 4; slots[1] = 2; slots[2] = 4; slots[3] = 1;
      slots[4] = 3; slots[5] = 2; slots[6] = 13; slots[7] = 0;
      slots[11] = 14; slots[15] = 15; slots[23] = 11; slots[24] = 12; slots[27] = 6;
      node_mode = 0;
      push_results(16'h0021, 16'hFFF2);
      load_words(28);
      check("t1_in_ready_rise", node_in_ready, 1);
      check("t1_busy_run", busy, 1);
      check("t1_s_ready_run", s_ready, 0);
      check_buses("t1");
      drain("t1");

      // Host stall in SEND0: first word must hold until m_ready returns
      m_ready = 1'b0;
      push_results(16'h0021, 16'hFFF2);
      load_words(28);
      g = 0;
      while (!m_valid && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("t2_m_valid_seen", m_valid, 1);
      for (int c = 0; c < 5; c++) begin
         check("t2_hold_valid", m_valid, 1);
         check("t2_hold_data", m_data, 16'h0021);
         check("t2_hold_last", m_last, 0);
         @(negedge clk);
      end
      m_ready = 1'b1;
      drain("t2");

      // out_ready tied high: must be ignored at rcnt 0, captured at rcnt 1
      for (int i = 0; i < 28; i++) slots[i] = 16'($urandom);
      node_mode = 1;
      push_results(16'($urandom), 16'($urandom));
      load_words(28);
      check("t3_run_entry", node_in_ready, 1);
      check("t3_no_valid_entry", m_valid, 0);
      @(negedge clk);
      check("t3_no_valid_entry1", m_valid, 0);
      @(negedge clk);
      check("t3_valid_entry2", m_valid, 1);
      check("t3_in_ready_drop", node_in_ready, 0);
      check_buses("t3");
      drain("t3");

      // Timeout: node never answers
      node_mode = 2;
      run_cyc = 0; te_cnt = 0; mv_cnt = 0; te_sready = 1'b0;
      load_words(28);
      for (int c = 0; c < 20; c++) begin
         if (node_in_ready) run_cyc++;
         if (m_valid) mv_cnt++;
         if (timeout_err) begin
            te_cnt++;
            te_sready = s_ready;
         end
         @(negedge clk);
      end
      check("t4_run_cycles", run_cyc, TO);
      check("t4_timeout_pulses", te_cnt, 1);
      check("t4_no_m_valid", mv_cnt, 0);
      check("t4_s_ready_at_err", te_sready, 1);
      check("t4_busy_after", busy, 0);

      // Reset after 10 words, then a full fresh load from slot 0
      node_mode = 0;
      for (int i = 0; i < 28; i++) slots[i] = 16'($urandom);
      load_words(10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("t5_reset");
      for (int i = 0; i < 28; i++) slots[i] = 16'(16'hA000 + i * 7);
      push_results(16'h1234, 16'h8765);
      load_words(28);
      check("t5_in_ready_rise", node_in_ready, 1);
      check_buses("t5");
      drain("t5");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
